hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Parametrised hazard and forwarding controller for the in-order RISC pipeline. It sits between decode and execute and tracks every in-flight register write in a per-stage scoreboard. It drives, per cycle, the decode stall, the branch squash and a per-source-operand forwarding select. Configurable pipeline depth, read-port count, per-class result latency and a stall-only mode replace the fixed single-stage hazard check and one-cycle stall flop of the current core.

## Interface
Parameters:
- REG_AW, 5: register address width; address 0 is hardwired zero.
- NUM_RD, 2: source operands checked per instruction.
- DEPTH, 3: stages after decode up to and including writeback (position 1 = EX, position DEPTH = WB).
- ALU_LAT, 1: first position at which an ALU result can be forwarded.
- LOAD_LAT, 2: first position at which a load result can be forwarded.
- FORWARD, 1: 1 = forwarding enabled; 0 = stall-only mode.
- FLUSH_LEN, 2: decode slots squashed after a taken branch.
- SEL_W, $clog2(DEPTH+1): forwarding select width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- issue_valid  in  1  decode holds a real instruction.
- issue_rw  in  1  instruction writes a register.
- issue_load  in  1  instruction is a load (uses LOAD_LAT).
- issue_dr  in  REG_AW  destination register.
- issue_src  in  NUM_RD*REG_AW  source registers; operand i at bits [i*REG_AW +: REG_AW].
- issue_src_used  in  NUM_RD  operand i is read from the register file.
- branch_taken  in  1  execute resolved a taken branch this cycle.
- stall  out  1  hold the PC, IF and decode registers; insert a bubble into EX.
- squash  out  1  convert the decode instruction to a NOP.
- issue_fire  out  1  instruction enters EX this cycle.
- fwd_sel  out  NUM_RD*SEL_W  per operand: 0 = register file, k = stage position k.
- stall_cnt  out  16  saturating count of stall cycles.
- squash_cnt  out  16  saturating count of squashed slots.

## Operation
- Scoreboard: entries pend[1..DEPTH], each holding {v, dr, lat}. lat is LOAD_LAT if issue_load, else ALU_LAT.
- Each cycle the scoreboard shifts: pend[k+1] ← pend[k]; pend[DEPTH] retires.
- pend[1] ← {issue_fire & issue_rw & (issue_dr≠0), issue_dr, lat}. Otherwise pend[1] receives a bubble (v=0).
- Operand i is checked only when issue_src_used[i] and issue_src[i]≠0; unchecked operands have fwd_sel=0 and no hazard.
- Match: the valid entry with dr = src and the smallest k (youngest) wins. Older matches are ignored.
- FORWARD=1: if the match has k ≥ lat, fwd_sel=k and no hazard. If k < lat, the operand is a hazard. No match: fwd_sel=0.
- FORWARD=0: any match is a hazard, including k=DEPTH, because the register file has no write-through. fwd_sel is always 0.
- Squash counter sq (0..FLUSH_LEN):
  - branch_taken loads sq=FLUSH_LEN, overriding any count in progress.
  - Otherwise sq decrements while nonzero.
  - squash = (sq≠0) & issue_valid.
- stall = issue_valid & ~squash & any hazard. Squash has priority over stall: a squashed slot never stalls.
- issue_fire = issue_valid & ~squash & ~stall.
- Counters increment by 1 on stall or on squash respectively, saturating at 0xFFFF.

## Timing
- stall, squash, issue_fire and fwd_sel are combinational from the inputs and registered state, valid in the same cycle.
- branch_taken in cycle t squashes decode in cycles t+1 .. t+FLUSH_LEN.
- Reset values:
  - All pend v=0; sq=0; both counters 0.
  - With issue_valid=0, every output is 0.
  - rst asserted mid-operation discards every in-flight entry on the next edge.
- branch_taken in the same cycle as rst is ignored.
- With rst low, branch_taken in the same cycle as a stall still reloads sq, and the stall is dropped from the next cycle.
- Stall latency, FORWARD=1, producer at pend[k] with latency L: lat−k stall cycles, then forwarding.
- Stall latency, FORWARD=0: DEPTH−k+1 stall cycles; the instruction fires in the cycle after the producer retires.

## Test plan
All scenarios use the default parameters unless stated.
- Reset: rst=1 for 2 cycles with issue_valid=1, issue_rw=1 → no pend entry becomes valid, stall=0, counters=0.
- ALU-use, FORWARD=1: issue r3←ALU, next cycle issue a read of r3 → stall=0, fwd_sel[0]=1.
- ALU-use, FORWARD=0: same stimulus → stall=1 for 3 cycles, then fire with fwd_sel=0; stall_cnt=3.
- Load-use: load r5, next cycle read r5 as operand 1 → stall for 1 cycle, then fwd_sel[1]=2.
- Writes to r0: any sequence of r0 writes followed by a read of r0 → never stalls.
- Youngest match: write r4 twice back to back, then read r4 → fwd_sel=1, not 2.
- Branch over stall: branch_taken during a load-use stall → squash=1 for 2 cycles, stall=0, squash_cnt=2.
- Counter saturation: preload 0xFFFF and stall once more → stall_cnt stays 0xFFFF.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Hazard and forwarding controller between decode and execute.
// Tracks in-flight register writes per stage and drives stall, squash and forwarding selects.
module hazard_scoreboard #(
  parameter int unsigned REG_AW    = 5,
  parameter int unsigned NUM_RD    = 2,
  parameter int unsigned DEPTH     = 3,
  parameter int unsigned ALU_LAT   = 1,
  parameter int unsigned LOAD_LAT  = 2,
  parameter int unsigned FORWARD   = 1,
  parameter int unsigned FLUSH_LEN = 2,
  parameter int unsigned SEL_W     = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     issue_valid,
  input  logic                     issue_rw,
  input  logic                     issue_load,
  input  logic [REG_AW-1:0]        issue_dr,
  input  logic [NUM_RD*REG_AW-1:0] issue_src,
  input  logic [NUM_RD-1:0]        issue_src_used,
  input  logic                     branch_taken,
  output logic                     stall,
  output logic                     squash,
  output logic                     issue_fire,
  output logic [NUM_RD*SEL_W-1:0]  fwd_sel,
  output logic [15:0]              stall_cnt,
  output logic [15:0]              squash_cnt
);

  localparam int unsigned MAX_LAT = (LOAD_LAT > ALU_LAT) ? LOAD_LAT : ALU_LAT;
  localparam int unsigned LAT_W   = (MAX_LAT > 0) ? $clog2(MAX_LAT + 1) : 1;
  localparam int unsigned SQ_W    = (FLUSH_LEN > 0) ? $clog2(FLUSH_LEN + 1) : 1;

  logic [DEPTH:1]    pend_v_q,   pend_v_d;
  logic [REG_AW-1:0] pend_dr_q   [1:DEPTH];
  logic [REG_AW-1:0] pend_dr_d   [1:DEPTH];
  logic [LAT_W-1:0]  pend_lat_q  [1:DEPTH];
  logic [LAT_W-1:0]  pend_lat_d  [1:DEPTH];
  logic [SQ_W-1:0]   sq_q,         sq_d;
  logic [15:0]       stall_cnt_q,  stall_cnt_d;
  logic [15:0]       squash_cnt_q, squash_cnt_d;

  logic                    hazard_c;
  logic [NUM_RD*SEL_W-1:0] fwd_c;
  logic [REG_AW-1:0]       src_c;
  logic                    found_c;
  int unsigned             match_k_c;
  int unsigned             match_lat_c;

  // Youngest-match search per source operand.
  always_comb begin
    hazard_c    = 1'b0;
    fwd_c       = '0;
    src_c       = '0;
    found_c     = 1'b0;
    match_k_c   = 0;
    match_lat_c = 0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      src_c       = issue_src[i*REG_AW +: REG_AW];
      found_c     = 1'b0;
      match_k_c   = 0;
      match_lat_c = 0;
      for (int unsigned k = 1; k <= DEPTH; k++) begin
        if (!found_c && pend_v_q[k] && (pend_dr_q[k] == src_c)) begin
          found_c     = 1'b1;
          match_k_c   = k;
          match_lat_c = 32'(pend_lat_q[k]);
        end
      end
      if (issue_src_used[i] && (src_c != '0) && found_c) begin
        if ((FORWARD != 0) && (match_k_c >= match_lat_c)) begin
          fwd_c[i*SEL_W +: SEL_W] = SEL_W'(match_k_c);
        end else begin
          hazard_c = 1'b1;
        end
      end
    end
  end

  assign squash     = (sq_q != '0) & issue_valid;
  assign stall      = issue_valid & ~squash & hazard_c;
  assign issue_fire = issue_valid & ~squash & ~stall;
  // A squashed slot becomes a NOP and reads nothing.
  assign fwd_sel    = (issue_valid & ~squash) ? fwd_c : '0;
  assign stall_cnt  = stall_cnt_q;
  assign squash_cnt = squash_cnt_q;

  // Scoreboard shift, squash window and saturating counters.
  always_comb begin
    pend_v_d      = pend_v_q;
    pend_v_d[1]   = issue_fire & issue_rw & (issue_dr != '0);
    pend_dr_d[1]  = issue_dr;
    pend_lat_d[1] = issue_load ? LAT_W'(LOAD_LAT) : LAT_W'(ALU_LAT);
    for (int unsigned k = 2; k <= DEPTH; k++) begin
      pend_v_d[k]   = pend_v_q[k-1];
      pend_dr_d[k]  = pend_dr_q[k-1];
      pend_lat_d[k] = pend_lat_q[k-1];
    end

    sq_d = sq_q;
    if (branch_taken) begin
      sq_d = SQ_W'(FLUSH_LEN);
    end else if (sq_q != '0) begin
      sq_d = sq_q - SQ_W'(1);
    end

    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
    squash_cnt_d = squash_cnt_q;
    if (squash && (squash_cnt_q != 16'hFFFF)) begin
      squash_cnt_d = squash_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_v_q     <= '0;
      sq_q         <= '0;
      stall_cnt_q  <= '0;
      squash_cnt_q <= '0;
    end else begin
      pend_v_q     <= pend_v_d;
      sq_q         <= sq_d;
      stall_cnt_q  <= stall_cnt_d;
      squash_cnt_q <= squash_cnt_d;
    end
  end

  // Payload fields are qualified by the valid bits, so they need no reset.
  always_ff @(posedge clk) begin
    for (int unsigned k = 1; k <= DEPTH; k++) begin
      pend_dr_q[k]  <= pend_dr_d[k];
      pend_lat_q[k] <= pend_lat_d[k];
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: forwarding, stall-only and long-run saturation instances.
module tb_hazard_scoreboard;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned NUM_RD = 2;
  localparam int unsigned SEL_W  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic issue_valid, issue_rw, issue_load, branch_taken;
  logic [REG_AW-1:0] issue_dr;
  logic [NUM_RD*REG_AW-1:0] issue_src;
  logic [NUM_RD-1:0] issue_src_used;

  logic d1_stall, d1_squash, d1_fire;
  logic [NUM_RD*SEL_W-1:0] d1_fwd;
  logic [15:0] d1_stall_cnt, d1_squash_cnt;

  logic dn_stall, dn_squash, dn_fire;
  logic [NUM_RD*SEL_W-1:0] dn_fwd;
  logic [15:0] dn_stall_cnt, dn_squash_cnt;

  logic ds_stall, ds_squash, ds_fire;
  logic [15:0] ds_fwd;
  logic [15:0] ds_stall_cnt, ds_squash_cnt;

  always #5 clk = ~clk;

  hazard_scoreboard u_fwd (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_rw(issue_rw),
    .issue_load(issue_load), .issue_dr(issue_dr), .issue_src(issue_src),
    .issue_src_used(issue_src_used), .branch_taken(branch_taken),
    .stall(d1_stall), .squash(d1_squash), .issue_fire(d1_fire), .fwd_sel(d1_fwd),
    .stall_cnt(d1_stall_cnt), .squash_cnt(d1_squash_cnt)
  );

  hazard_scoreboard #(.FORWARD(0)) u_nofwd (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_rw(issue_rw),
    .issue_load(issue_load), .issue_dr(issue_dr), .issue_src(issue_src),
    .issue_src_used(issue_src_used), .branch_taken(branch_taken),
    .stall(dn_stall), .squash(dn_squash), .issue_fire(dn_fire), .fwd_sel(dn_fwd),
    .stall_cnt(dn_stall_cnt), .squash_cnt(dn_squash_cnt)
  );

  hazard_scoreboard #(.DEPTH(255), .FORWARD(0)) u_sat (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_rw(issue_rw),
    .issue_load(issue_load), .issue_dr(issue_dr), .issue_src(issue_src),
    .issue_src_used(issue_src_used), .branch_taken(branch_taken),
    .stall(ds_stall), .squash(ds_squash), .issue_fire(ds_fire), .fwd_sel(ds_fwd),
    .stall_cnt(ds_stall_cnt), .squash_cnt(ds_squash_cnt)
  );

  typedef struct packed {
    logic                    stall;
    logic                    squash;
    logic                    fire;
    logic [NUM_RD*SEL_W-1:0] fwd;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic v, input logic rw, input logic ld, input logic [4:0] dr,
                       input logic [4:0] s1, input logic [4:0] s0, input logic [1:0] used,
                       input logic br);
    issue_valid    = v;
    issue_rw       = rw;
    issue_load     = ld;
    issue_dr       = dr;
    issue_src      = {s1, s0};
    issue_src_used = used;
    branch_taken   = br;
  endtask

  // Drive one decode slot, queue its expected outputs, compare mid-cycle, advance one edge.
  task automatic step(input string tag, input bit use_nf,
                      input logic v, input logic rw, input logic ld, input logic [4:0] dr,
                      input logic [4:0] s1, input logic [4:0] s0, input logic [1:0] used,
                      input logic br,
                      input logic e_stall, input logic e_sq, input logic e_fire,
                      input logic [3:0] e_fwd);
    exp_t e;
    drive(v, rw, ld, dr, s1, s0, used, br);
    exp_q.push_back('{stall: e_stall, squash: e_sq, fire: e_fire, fwd: e_fwd});
    @(negedge clk);
    e = exp_q.pop_front();
    chk({tag, ".stall"},  32'(use_nf ? dn_stall  : d1_stall),  32'(e.stall));
    chk({tag, ".squash"}, 32'(use_nf ? dn_squash : d1_squash), 32'(e.squash));
    chk({tag, ".fire"},   32'(use_nf ? dn_fire   : d1_fire),   32'(e.fire));
    chk({tag, ".fwd"},    32'(use_nf ? dn_fwd    : d1_fwd),    32'(e.fwd));
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held two cycles while decode offers a register write.
    drive(1'b1, 1'b1, 1'b0, 5'd7, 5'd0, 5'd0, 2'b00, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    step("idle",      0, 0,0,0,5'd0, 5'd0,5'd0, 2'b00, 0,  0,0,0, 4'h0);
    step("rst_r7",    0, 1,0,0,5'd0, 5'd0,5'd7, 2'b01, 0,  0,0,1, 4'h0);
    chk("rst_stall_cnt",  32'(d1_stall_cnt),  32'd0);
    chk("rst_squash_cnt", 32'(d1_squash_cnt), 32'd0);
    chk("rst_nf_stall_cnt", 32'(dn_stall_cnt), 32'd0);

    // ALU producer forwarded from EX.
    step("alu_w",     0, 1,1,0,5'd3, 5'd0,5'd0, 2'b00, 0,  0,0,1, 4'h0);
    step("alu_use",   0, 1,0,0,5'd0, 5'd0,5'd3, 2'b01, 0,  0,0,1, 4'h1);

    // Load-use on operand 1: one stall, then forward from position 2.
    step("ld_w",      0, 1,1,1,5'd5, 5'd0,5'd0, 2'b00, 0,  0,0,1, 4'h0);
    step("ld_use0",   0, 1,0,0,5'd0, 5'd5,5'd0, 2'b10, 0,  1,0,0, 4'h0);
    step("ld_use1",   0, 1,0,0,5'd0, 5'd5,5'd0, 2'b10, 0,  0,0,1, 4'h8);
    chk("ld_stall_cnt", 32'(d1_stall_cnt), 32'd1);

    // r0 writes never create hazards.
    step("r0_w_alu",  0, 1,1,0,5'd0, 5'd0,5'd0, 2'b00, 0,  0,0,1, 4'h0);
    step("r0_w_ld",   0, 1,1,1,5'd0, 5'd0,5'd0, 2'b00, 0,  0,0,1, 4'h0);
    step("r0_read",   0, 1,0,0,5'd0, 5'd0,5'd0, 2'b11, 0,  0,0,1, 4'h0);

    // Back-to-back writes of r4: the younger one forwards.
    step("yng_w1",    0, 1,1,0,5'd4, 5'd0,5'd0, 2'b00, 0,  0,0,1, 4'h0);
    step("yng_w2",    0, 1,1,0,5'd4, 5'd0,5'd0, 2'b00, 0,  0,0,1, 4'h0);
    step("yng_use",   0, 1,0,0,5'd0, 5'd0,5'd4, 2'b01, 0,  0,0,1, 4'h1);

    // Taken branch during a load-use stall squashes two slots.
    step("br_ld",     0, 1,1,1,5'd6, 5'd0,5'd0, 2'b00, 0,  0,0,1, 4'h0);
    step("br_stall",  0, 1,0,0,5'd0, 5'd0,5'd6, 2'b01, 1,  1,0,0, 4'h0);
    step("br_sq1",    0, 1,0,0,5'd0, 5'd0,5'd6, 2'b01, 0,  0,1,0, 4'h0);
    step("br_sq2",    0, 1,0,0,5'd0, 5'd0,5'd6, 2'b01, 0,  0,1,0, 4'h0);
    step("br_after",  0, 1,0,0,5'd0, 5'd0,5'd6, 2'b01, 0,  0,0,1, 4'h0);
    chk("br_stall_cnt",  32'(d1_stall_cnt),  32'd2);
    chk("br_squash_cnt", 32'(d1_squash_cnt), 32'd2);

    // Stall-only instance: ALU-use waits until the producer retires.
    drive(0,0,0,5'd0, 5'd0,5'd0, 2'b00, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    step("nf_w",      1, 1,1,0,5'd3, 5'd0,5'd0, 2'b00, 0,  0,0,1, 4'h0);
    step("nf_use0",   1, 1,0,0,5'd0, 5'd0,5'd3, 2'b01, 0,  1,0,0, 4'h0);
    step("nf_use1",   1, 1,0,0,5'd0, 5'd0,5'd3, 2'b01, 0,  1,0,0, 4'h0);
    step("nf_use2",   1, 1,0,0,5'd0, 5'd0,5'd3, 2'b01, 0,  1,0,0, 4'h0);
    step("nf_use3",   1, 1,0,0,5'd0, 5'd0,5'd3, 2'b01, 0,  0,0,1, 4'h0);
    chk("nf_stall_cnt", 32'(dn_stall_cnt), 32'd3);

    // Deep stall-only instance: a self-dependent instruction stalls 255 of every 256 cycles.
    drive(0,0,0,5'd0, 5'd0,5'd0, 2'b00, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1,1,0,5'd9, 5'd0,5'd9, 2'b01, 0);
    repeat (256) @(posedge clk);
    #1;
    chk("sat_partial", 32'(ds_stall_cnt), 32'd255);
    repeat (65836) @(posedge clk);
    #1;
    chk("sat_stall_cnt",  32'(ds_stall_cnt),  32'hFFFF);
    chk("sat_squash_cnt", 32'(ds_squash_cnt), 32'd0);
    chk("sat_stall",      32'(ds_stall),      32'd1);
    chk("sat_fire",       32'(ds_fire),       32'd0);
    chk("sat_squash",     32'(ds_squash),     32'd0);
    chk("sat_fwd",        32'(ds_fwd),        32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
